bsg_manycore_core_req_arbiter: RTL and testbench

Parametrised N-core remote-request arbiter and response router that lets several vanilla cores share one manycore endpoint. It sits between each core's remote_req/remote-load-response interface and a single endpoint TX/returned port. It multiplexes requests with round-robin fairness, tags each outstanding request, enforces per-core and global outstanding limits, and steers each returned packet to its originating core with the original reg_id restored.

---
 rtl/bsg_manycore_core_req_arbiter.sv | 164 ++++++++++++++++
 tb/tb_bsg_manycore_core_req_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_core_req_arbiter.sv
// Round-robin N-core remote-request arbiter with tag table; request and return paths are combinational (0 cycles).
// Backpressure: out_ready_i gates req_yumi_o; resp_yumi_i gates returned_yumi_o; full table or exhausted core credits block grants.
module bsg_manycore_core_req_arbiter #(
    parameter int num_cores_p    = 2,
    parameter int packet_width_p = 80,
    parameter int data_width_p   = 32,
    parameter int reg_id_width_p = 5,
    parameter int num_tags_p     = 16,
    parameter int core_credits_p = 8,
    localparam int tag_width_lp     = (num_tags_p > 1) ? $clog2(num_tags_p) : 1,
    localparam int core_id_width_lp = (num_cores_p > 1) ? $clog2(num_cores_p) : 1,
    localparam int count_width_lp   = $clog2(core_credits_p + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [num_cores_p-1:0]                   req_v_i,
    input  logic [num_cores_p*packet_width_p-1:0]    req_packet_i,
    input  logic [num_cores_p*reg_id_width_p-1:0]    req_reg_id_i,
    output logic [num_cores_p-1:0]                   req_yumi_o,
    output logic                                     out_v_o,
    output logic [packet_width_p-1:0]                out_packet_o,
    output logic [tag_width_lp-1:0]                  out_tag_o,
    input  logic                                     out_ready_i,
    input  logic                                     returned_v_i,
    input  logic [tag_width_lp-1:0]                  returned_tag_i,
    input  logic [data_width_p-1:0]                  returned_data_i,
    output logic                                     returned_yumi_o,
    output logic [num_cores_p-1:0]                   resp_v_o,
    output logic [data_width_p-1:0]                  resp_data_o,
    output logic [reg_id_width_p-1:0]                resp_reg_id_o,
    input  logic [num_cores_p-1:0]                   resp_yumi_i,
    output logic [num_cores_p*count_width_lp-1:0]    credits_used_o,
    output logic                                     error_o
);

    typedef struct packed {
        logic [core_id_width_lp-1:0] core;
        logic [reg_id_width_p-1:0]   reg_id;
    } entry_t;

    localparam logic [count_width_lp-1:0] credit_limit = count_width_lp'(core_credits_p);

    logic [num_tags_p-1:0]       valid_r;
    entry_t                      table_r [num_tags_p];
    logic [count_width_lp-1:0]   count_r [num_cores_p];
    logic [count_width_lp-1:0]   count_next [num_cores_p];
    logic [core_id_width_lp-1:0] rr_r;
    logic                        error_r;

    logic [num_cores_p-1:0]      eligible;
    logic                        grant_found;
    logic [core_id_width_lp-1:0] grant_id;
    logic [core_id_width_lp-1:0] next_rr;
    logic [tag_width_lp-1:0]     free_tag;
    logic                        table_full;
    logic                        alloc;
    int                          cand;

    entry_t                      ret_entry;
    logic                        tag_in_range;
    logic                        entry_valid;
    logic                        hit;
    logic                        release_tag;
    logic                        bad_tag;

    always_comb begin
        for (int c = 0; c < num_cores_p; c++) begin
            eligible[c] = req_v_i[c] && (count_r[c] < credit_limit);
        end
    end

    // Search starts at rr_r and wraps, so the first eligible core found wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int i = 0; i < num_cores_p; i++) begin
            cand = int'(rr_r) + i;
            if (cand >= num_cores_p) cand = cand - num_cores_p;
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_id    = core_id_width_lp'(cand);
            end
        end
    end

    always_comb begin
        free_tag = '0;
        for (int t = num_tags_p - 1; t >= 0; t--) begin
            if (!valid_r[t]) free_tag = tag_width_lp'(t);
        end
    end

    assign table_full   = &valid_r;
    assign out_v_o      = reset_n_i & grant_found & ~table_full;
    assign out_packet_o = req_packet_i[grant_id*packet_width_p +: packet_width_p];
    assign out_tag_o    = free_tag;
    assign alloc        = out_v_o & out_ready_i;
    assign req_yumi_o   = alloc ? (num_cores_p'(1) << grant_id) : '0;
    assign next_rr      = (grant_id == core_id_width_lp'(num_cores_p - 1)) ? '0
                        : grant_id + core_id_width_lp'(1);

    generate
        if ((2 ** tag_width_lp) == num_tags_p) begin : g_pow2_tags
            assign tag_in_range = 1'b1;
        end else begin : g_odd_tags
            assign tag_in_range = (returned_tag_i < tag_width_lp'(num_tags_p));
        end
    endgenerate

    assign ret_entry       = table_r[returned_tag_i];
    assign entry_valid     = tag_in_range & valid_r[returned_tag_i];
    assign hit             = reset_n_i & returned_v_i & entry_valid;
    assign resp_v_o        = hit ? (num_cores_p'(1) << ret_entry.core) : '0;
    assign resp_data_o     = returned_data_i;
    assign resp_reg_id_o   = ret_entry.reg_id;
    assign release_tag     = |(resp_v_o & resp_yumi_i);
    // Unknown tags are swallowed so the endpoint never stalls on them.
    assign bad_tag         = reset_n_i & returned_v_i & ~entry_valid;
    assign returned_yumi_o = release_tag | bad_tag;

    always_comb begin
        for (int c = 0; c < num_cores_p; c++) begin
            count_next[c] = count_r[c];
            if ((alloc && grant_id == core_id_width_lp'(c)) &&
                !(release_tag && ret_entry.core == core_id_width_lp'(c))) begin
                count_next[c] = count_r[c] + count_width_lp'(1);
            end else if (!(alloc && grant_id == core_id_width_lp'(c)) &&
                         (release_tag && ret_entry.core == core_id_width_lp'(c))) begin
                count_next[c] = count_r[c] - count_width_lp'(1);
            end
        end
    end

    // Freed and allocated tags never collide: allocation only picks tags invalid in valid_r.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_r <= '0;
            rr_r    <= '0;
            error_r <= 1'b0;
            for (int t = 0; t < num_tags_p; t++) table_r[t] <= '0;
            for (int c = 0; c < num_cores_p; c++) count_r[c] <= '0;
        end else begin
            if (release_tag) valid_r[returned_tag_i] <= 1'b0;
            if (alloc) begin
                valid_r[free_tag]        <= 1'b1;
                table_r[free_tag].core   <= grant_id;
                table_r[free_tag].reg_id <= req_reg_id_i[grant_id*reg_id_width_p +: reg_id_width_p];
                rr_r                     <= next_rr;
            end
            if (bad_tag) error_r <= 1'b1;
            for (int c = 0; c < num_cores_p; c++) count_r[c] <= count_next[c];
        end
    end

    generate
        for (genvar c = 0; c < num_cores_p; c++) begin : g_credits
            assign credits_used_o[c*count_width_lp +: count_width_lp] = count_r[c];
        end
    endgenerate

    assign error_o = error_r;

endmodule

// File: tb/tb_bsg_manycore_core_req_arbiter.sv
// Bench for bsg_manycore_core_req_arbiter: directed scenarios plus a per-cycle reference model.
module tb_bsg_manycore_core_req_arbiter;

    localparam int NC = 2;
    localparam int PW = 80;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int NT = 16;
    localparam int CR = 8;
    localparam int TW = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NC-1:0]   req_v;
    logic [NC*PW-1:0] req_packet;
    logic [NC*RW-1:0] req_reg_id;
    logic [NC-1:0]   req_yumi;
    logic            out_v;
    logic [PW-1:0]   out_packet;
    logic [TW-1:0]   out_tag;
    logic            out_ready;
    logic            returned_v;
    logic [TW-1:0]   returned_tag;
    logic [DW-1:0]   returned_data;
    logic            returned_yumi;
    logic [NC-1:0]   resp_v;
    logic [DW-1:0]   resp_data;
    logic [RW-1:0]   resp_reg_id;
    logic [NC-1:0]   resp_yumi;
    logic [NC*CW-1:0] credits_used;
    logic            error;

    always #5 clk = ~clk;

    bsg_manycore_core_req_arbiter #(
        .num_cores_p(NC), .packet_width_p(PW), .data_width_p(DW),
        .reg_id_width_p(RW), .num_tags_p(NT), .core_credits_p(CR)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_v_i(req_v), .req_packet_i(req_packet), .req_reg_id_i(req_reg_id),
        .req_yumi_o(req_yumi),
        .out_v_o(out_v), .out_packet_o(out_packet), .out_tag_o(out_tag),
        .out_ready_i(out_ready),
        .returned_v_i(returned_v), .returned_tag_i(returned_tag),
        .returned_data_i(returned_data), .returned_yumi_o(returned_yumi),
        .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_reg_id_o(resp_reg_id),
        .resp_yumi_i(resp_yumi),
        .credits_used_o(credits_used), .error_o(error)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt(input int c);
        return int'(credits_used[c*CW +: CW]);
    endfunction

    // Reference model: outstanding table as plain arrays, updated once per clock.
    bit mvalid [NT];
    int mcore  [NT];
    int mreg   [NT];
    int mcount [NC];
    int mrr;
    bit merr;
    bit nvalid [NT];
    int ncore  [NT];
    int nreg   [NT];
    int ncount [NC];
    int nrr;
    bit nerr;

    always @(negedge clk) begin : model_compare
        int g, c, ft, t;
        bit has, full, ev, hitv, ery;
        logic [NC-1:0] ey, erv;
        has = 1'b0; g = 0;
        for (int i = 0; i < NC; i++) begin
            c = (mrr + i) % NC;
            if (!has && req_v[c] && mcount[c] < CR) begin
                has = 1'b1; g = c;
            end
        end
        full = 1'b1; ft = 0;
        for (int k = NT - 1; k >= 0; k--) if (!mvalid[k]) begin full = 1'b0; ft = k; end
        ev = rst_n && has && !full;
        check("m_out_v", out_v, ev);
        if (ev) begin
            check("m_out_tag", out_tag, ft);
            check("m_out_packet", out_packet, req_packet[g*PW +: PW]);
        end
        ey = (ev && out_ready) ? NC'(1 << g) : '0;
        check("m_req_yumi", req_yumi, ey);
        t = int'(returned_tag);
        hitv = rst_n && returned_v && mvalid[t];
        erv = hitv ? NC'(1 << mcore[t]) : '0;
        check("m_resp_v", resp_v, erv);
        if (hitv) check("m_resp_reg_id", resp_reg_id, mreg[t]);
        if (returned_v) check("m_resp_data", resp_data, returned_data);
        ery = rst_n && returned_v && (!mvalid[t] || resp_yumi[mcore[t]]);
        check("m_returned_yumi", returned_yumi, ery);
        for (int k = 0; k < NC; k++) check("m_credits", cnt(k), mcount[k]);
        check("m_error", error, merr);

        nvalid = mvalid; ncore = mcore; nreg = mreg; ncount = mcount; nrr = mrr; nerr = merr;
        if (ey != '0) begin
            nvalid[ft] = 1'b1;
            ncore[ft]  = g;
            nreg[ft]   = int'(req_reg_id[g*RW +: RW]);
            ncount[g]  = ncount[g] + 1;
            nrr        = (g + 1) % NC;
        end
        if (ery && mvalid[t]) begin
            nvalid[t] = 1'b0;
            ncount[mcore[t]] = ncount[mcore[t]] - 1;
        end
        if (rst_n && returned_v && !mvalid[t]) nerr = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NT; k++) begin mvalid[k] = 1'b0; mcore[k] = 0; mreg[k] = 0; end
            for (int k = 0; k < NC; k++) mcount[k] = 0;
            mrr = 0; merr = 1'b0;
            nvalid = mvalid; ncore = mcore; nreg = mreg; ncount = mcount; nrr = 0; nerr = 1'b0;
        end else begin
            mvalid = nvalid; mcore = ncore; mreg = nreg; mcount = ncount; mrr = nrr; merr = nerr;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_v = '0; out_ready = 1'b0; returned_v = 1'b0; returned_tag = '0;
        returned_data = '0; resp_yumi = '0;
    endtask

    task automatic set_pkts();
        for (int c = 0; c < NC; c++) begin
            req_packet[c*PW +: PW] = {16'($urandom), 32'($urandom), 32'($urandom)};
            req_reg_id[c*RW +: RW] = RW'($urandom);
        end
    endtask

    task automatic do_reset();
        cyc();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        req_packet = '0;
        req_reg_id = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_v = 2'b11; out_ready = 1'b1; returned_v = 1'b1; resp_yumi = 2'b11; set_pkts();
        #1;
        check("rst_out_v", out_v, 0);
        check("rst_req_yumi", req_yumi, 0);
        check("rst_returned_yumi", returned_yumi, 0);
        check("rst_resp_v", resp_v, 0);
        check("rst_credits", credits_used, 0);
        check("rst_error", error, 0);
        idle();
        rst_n = 1'b1;

        // Single core: three requests then one return
        for (int k = 0; k < 3; k++) begin
            cyc(); set_pkts();
            req_v = 2'b01; out_ready = 1'b1; req_reg_id[RW-1:0] = RW'(5 + k);
            #2;
            check("t1_tag", out_tag, k);
            check("t1_yumi", req_yumi, 2'b01);
        end
        cyc(); idle();
        returned_v = 1'b1; returned_tag = 4'd1; returned_data = 32'hABCD; resp_yumi = 2'b01;
        #2;
        check("t1_resp_v", resp_v, 2'b01);
        check("t1_resp_reg", resp_reg_id, 6);
        check("t1_resp_data", resp_data, 32'hABCD);
        check("t1_ret_yumi", returned_yumi, 1);
        check("t1_cnt_before", cnt(0), 3);
        cyc(); idle();
        #2;
        check("t1_cnt_after", cnt(0), 2);

        // Fairness and hold under out_ready low
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(); set_pkts(); req_v = 2'b11; out_ready = 1'b1;
            #2;
            check("t2_rr", req_yumi, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(); out_ready = 1'b0;
            #2;
            check("t2_hold_v", out_v, 1);
            check("t2_hold_yumi", req_yumi, 0);
        end
        cyc(); out_ready = 1'b1;
        #2;
        check("t2_resume", req_yumi, 2'b01);
        cyc(); idle();

        // Per-core credit limit
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(); set_pkts(); req_v = 2'b01; out_ready = 1'b1;
            #2;
            check("t3_tag", out_tag, k);
        end
        cyc(); set_pkts(); req_v = 2'b11;
        #2;
        check("t3_blocked", req_yumi, 2'b10);
        cyc(); set_pkts(); req_v = 2'b11;
        returned_v = 1'b1; returned_tag = 4'd0; resp_yumi = 2'b01;
        #2;
        check("t3_ret_cycle", req_yumi, 2'b10);
        check("t3_ret_yumi", returned_yumi, 1);
        cyc(); returned_v = 1'b0; resp_yumi = '0;
        #2;
        check("t3_regrant", req_yumi, 2'b01);
        check("t3_regrant_tag", out_tag, 0);
        cyc(); idle();

        // Table full, then same-cycle free and request
        do_reset();
        for (int k = 0; k < 16; k++) begin
            cyc(); set_pkts(); req_v = 2'b11; out_ready = 1'b1;
            #2;
            check("t4_tag", out_tag, k);
        end
        cyc();
        #2;
        check("t4_full_v", out_v, 0);
        check("t4_full_yumi", req_yumi, 0);
        cyc(); returned_v = 1'b1; returned_tag = 4'd3; resp_yumi = 2'b10;
        #2;
        check("t4_free_v", out_v, 0);
        check("t4_free_resp", resp_v, 2'b10);
        cyc(); returned_v = 1'b0; resp_yumi = '0;
        #2;
        check("t4_realloc_v", out_v, 1);
        check("t4_realloc_tag", out_tag, 3);
        check("t4_realloc_yumi", req_yumi, 2'b10);

        // Response back-pressure, then unallocated tag
        cyc(); req_v = '0;
        returned_v = 1'b1; returned_tag = 4'd5; returned_data = 32'h1234_5678; resp_yumi = 2'b01;
        #2;
        check("t5_bp_resp", resp_v, 2'b10);
        check("t5_bp_yumi", returned_yumi, 0);
        cyc();
        #2;
        check("t5_bp_data", resp_data, 32'h1234_5678);
        check("t5_bp_yumi2", returned_yumi, 0);
        cyc(); resp_yumi = 2'b10;
        #2;
        check("t5_accept", returned_yumi, 1);
        cyc(); returned_tag = 4'd9; returned_data = 32'h0000_0099;
        #2;
        check("t5_tag9_resp", resp_v, 2'b10);
        cyc();
        #2;
        check("t5_bad_resp", resp_v, 0);
        check("t5_bad_yumi", returned_yumi, 1);
        check("t5_bad_err_now", error, 0);
        cyc(); idle();
        #2;
        check("t5_err_set", error, 1);
        repeat (3) cyc();
        #2;
        check("t5_err_sticky", error, 1);

        // Asynchronous reset in the middle of traffic
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(); set_pkts(); req_v = 2'b01; out_ready = 1'b1;
        end
        cyc(); set_pkts(); req_v = 2'b01; returned_v = 1'b1; returned_tag = 4'd2; resp_yumi = 2'b01;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_out_v", out_v, 0);
        check("t6_req_yumi", req_yumi, 0);
        check("t6_resp_v", resp_v, 0);
        check("t6_ret_yumi", returned_yumi, 0);
        check("t6_credits", credits_used, 0);
        check("t6_error", error, 0);
        cyc(); idle();
        #2;
        rst_n = 1'b1;
        cyc(); set_pkts(); req_v = 2'b01; out_ready = 1'b1;
        #2;
        check("t6_first_tag", out_tag, 0);
        check("t6_first_yumi", req_yumi, 2'b01);
        check("t6_cnt0", cnt(0), 0);
        check("t6_cnt1", cnt(1), 0);
        cyc(); idle();
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
